// File: rtl/scff_io_chain_if.sv
// Pad and fabric bundle of the scan-chain block; the master drives pads/fabric inputs, the slave is the block.
interface scff_io_chain_if #(
    parameter int SC_LEN = 1024
);
    logic [37:0]       io_in;
    logic [37:0]       io_out;
    logic [37:0]       io_oeb;
    logic [SC_LEN-1:0] func_d;
    logic [SC_LEN-1:0] func_q;
    logic              ccff_tail_i;

    modport master (
        output io_in,
        output func_d,
        output ccff_tail_i,
        input  io_out,
        input  io_oeb,
        input  func_q
    );

    modport slave (
        input  io_in,
        input  func_d,
        input  ccff_tail_i,
        output io_out,
        output io_oeb,
        output func_q
    );
endinterface

// File: rtl/scff_io_chain.sv
// Scan flop chain with fixed mprj_io pin map: shift/capture one op_clk edge per step, pads combinational.
// No backpressure: the chain advances every edge; io_out follows flops and isolation without a register.
module scff_io_chain #(
    parameter int SC_LEN = 1024
) (
    input  logic             op_clk,
    input  logic             Reset,
    scff_io_chain_if.slave   bus
);
    localparam logic [37:0] OEB_CONST = ~((38'd1 << 11) | (38'd1 << 35));

    logic [SC_LEN-1:0] sc_q;
    logic [SC_LEN-1:0] sc_d;
    logic              test_en;
    logic              io_isol_n;
    logic              sc_head;
    logic              sc_tail;
    logic              unused_io;

    assign test_en   = bus.io_in[0];
    assign io_isol_n = bus.io_in[1];
    assign sc_head   = bus.io_in[26];
    // Input-only pads and the pads owned by other paths are deliberately ignored.
    assign unused_io = ^{bus.io_in[37:27], bus.io_in[25:2]};

    always_comb begin
        sc_d = bus.func_d;
        if (test_en) begin
            sc_d = {sc_q[SC_LEN-2:0], sc_head};
        end
    end

    always_ff @(posedge op_clk) begin
        if (!Reset) begin
            sc_q <= '0;
        end else begin
            sc_q <= sc_d;
        end
    end

    assign sc_tail    = sc_q[SC_LEN-1];
    assign bus.func_q = sc_q;
    assign bus.io_oeb = OEB_CONST;

    always_comb begin
        bus.io_out     = '0;
        bus.io_out[11] = sc_tail & io_isol_n;
        bus.io_out[35] = bus.ccff_tail_i & io_isol_n;
    end
endmodule

// File: tb/tb_scff_io_chain.sv
// Randomized self-checking bench for scff_io_chain against a queue-based chain model.
module tb_scff_io_chain;
    localparam int SCL = 1024;
    localparam logic [37:0] OEB_EXP = 38'h37_FFFF_F7FF;

    logic op_clk;
    logic Reset;
    scff_io_chain_if #(.SC_LEN(SCL)) bus ();

    scff_io_chain #(.SC_LEN(SCL)) dut (
        .op_clk (op_clk),
        .Reset  (Reset),
        .bus    (bus)
    );

    initial op_clk = 1'b0;
    always #5 op_clk = ~op_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: mq[0] is the flop nearest scan-in, mq[SCL-1] is the tail.
    logic mq[$];

    task automatic check(input string tag, input logic [SCL-1:0] obs, input logic [SCL-1:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [SCL-1:0] model_vec();
        logic [SCL-1:0] v;
        for (int i = 0; i < SCL; i++) v[i] = mq[i];
        return v;
    endfunction

    function automatic logic [37:0] model_out();
        logic [37:0] o;
        o     = '0;
        o[11] = mq[SCL-1] & bus.io_in[1];
        o[35] = bus.ccff_tail_i & bus.io_in[1];
        return o;
    endfunction

    function automatic logic [SCL-1:0] rand_vec();
        logic [SCL-1:0] v;
        for (int i = 0; i < SCL / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One op_clk edge: advance the model from the inputs held at the edge, then settle away from it.
    task automatic step();
        @(posedge op_clk);
        if (!Reset) begin
            for (int i = 0; i < SCL; i++) mq[i] = 1'b0;
        end else if (bus.io_in[0]) begin
            mq.push_front(bus.io_in[26]);
            void'(mq.pop_back());
        end else begin
            for (int i = 0; i < SCL; i++) mq[i] = bus.func_d[i];
        end
        #2;
    endtask

    task automatic set_pads(input logic ten, input logic isol, input logic head);
        bus.io_in     = 38'($urandom) ^ (38'($urandom) << 32);
        bus.io_in[0]  = ten;
        bus.io_in[1]  = isol;
        bus.io_in[26] = head;
    endtask

    logic [SCL-1:0] pat;
    logic [SCL-1:0] alt;
    logic           tail_seen;

    initial begin
        for (int i = 0; i < SCL; i++) mq.push_back(1'bx);
        Reset           = 1'b0;
        bus.func_d      = '0;
        bus.ccff_tail_i = 1'b0;
        set_pads(1'b1, 1'b1, 1'b1);

        // Reset held while shifting ones in
        for (int k = 0; k < 3; k++) step();
        check("rst_func_q", bus.func_q, '0);
        check("rst_tail", bus.io_out[11], 1'b0);
        check("rst_io_out", bus.io_out, '0);
        check("rst_io_oeb", bus.io_oeb, OEB_EXP);

        // Single pulse through the full chain
        Reset = 1'b1;
        set_pads(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= SCL + 2; k++) begin
            step();
            if (k == 1) set_pads(1'b1, 1'b1, 1'b0);
            else        set_pads(1'b1, 1'b1, 1'b0);
            check($sformatf("pulse_e%0d", k), bus.io_out[11], (k == SCL) ? 1'b1 : 1'b0);
        end
        check("pulse_model", bus.func_q, model_vec());

        // Capture an alternating pattern, then unload it
        for (int i = 0; i < SCL; i++) alt[i] = (i % 2 == 1);
        bus.func_d = alt;
        set_pads(1'b0, 1'b1, 1'b0);
        step();
        check("capture", bus.func_q, alt);
        set_pads(1'b1, 1'b1, 1'b0);
        #1;
        check("unload_0", bus.io_out[11], alt[SCL-1]);
        for (int j = 1; j <= 8; j++) begin
            step();
            set_pads(1'b1, 1'b1, 1'b0);
            #1;
            check($sformatf("unload_%0d", j), bus.io_out[11], alt[SCL-1-j]);
        end

        // Random mix of shift, capture, isolation and occasional reset
        for (int k = 0; k < 400; k++) begin
            Reset = ($urandom_range(0, 29) != 0);
            set_pads(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom));
            bus.ccff_tail_i = 1'($urandom);
            if ($urandom_range(0, 4) == 0) bus.func_d = rand_vec();
            step();
            check("rand_func_q", bus.func_q, model_vec());
            check("rand_io_out", bus.io_out, model_out());
        end
        Reset = 1'b1;

        // Isolation gates both driven pads without a clock edge
        pat            = rand_vec();
        pat[SCL-1]     = 1'b1;
        bus.func_d     = pat;
        set_pads(1'b0, 1'b1, 1'b0);
        step();
        set_pads(1'b1, 1'b0, 1'b0);
        bus.ccff_tail_i = 1'b1;
        #1;
        check("isol_io_out", bus.io_out, '0);
        check("isol_oeb", bus.io_oeb, OEB_EXP);
        bus.io_in[1] = 1'b1;
        #1;
        check("unisol_11", bus.io_out[11], 1'b1);
        check("unisol_35", bus.io_out[35], 1'b1);
        check("unisol_all", bus.io_out, (38'd1 << 11) | (38'd1 << 35));

        // Reset mid-shift kills a pulse in flight
        bus.func_d = '0;
        set_pads(1'b0, 1'b1, 1'b0);
        step();
        set_pads(1'b1, 1'b1, 1'b1);
        step();
        for (int k = 0; k < 500; k++) begin
            set_pads(1'b1, 1'b1, 1'b0);
            step();
        end
        check("mid_inflight", bus.func_q, model_vec());
        Reset = 1'b0;
        step();
        check("mid_rst", bus.func_q, '0);
        Reset     = 1'b1;
        tail_seen = 1'b0;
        for (int k = 0; k < SCL + 8; k++) begin
            set_pads(1'b1, 1'b1, 1'b0);
            step();
            tail_seen = tail_seen | bus.io_out[11];
        end
        check("mid_no_pulse", tail_seen, 1'b0);
        check("mid_final", bus.func_q, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/scff_io_chain.md
# scff_io_chain

User-area scan-chain block with a fixed Caravel `mprj_io` pin map. It implements a parameterizable-length scan flip-flop chain (scan-in on pad 26, scan-out on pad 11) clocked by the FPGA operating clock. The block also handles pad direction control and isolation for the user GPIOs. It sits between the Caravel `mprj_io` pads and the FPGA fabric core and serves as the scan-test path for the fabric.

## Interface
Parameters:
- `SC_LEN`, default 1024: number of scan flops; minimum 2.

Ports:
- `op_clk`  in  1  operating clock (pad 36); all flops are rising-edge.
- `Reset`  in  1  one clock; reset is synchronous and active-low.
- `io_in`  in  38  pad input values from `mprj_io`.
- `io_out`  out  38  pad output values.
- `io_oeb`  out  38  pad output-enable, active-low (0 = block drives the pad).
- `func_d`  in  SC_LEN  functional capture data from the fabric.
- `func_q`  out  SC_LEN  current scan-flop contents to the fabric.
- `ccff_tail_i`  in  1  configuration-chain tail from the fabric, routed to pad 35.

## Operation
- Decoded pad inputs:
  - `Test_en` = `io_in[0]`
  - `IO_ISOL_N` = `io_in[1]`
  - `sc_head` = `io_in[26]`
  - `io_in[2]`, `[3]`, `[12]`, `[25]`, `[37]` are inputs only and are not used internally.
- Scan chain: register `sc[SC_LEN-1:0]`, updated on `op_clk` rising edge, priority order:
  1. `Reset`=0: `sc` <= all zeros.
  2. `Test_en`=1 (shift): `sc[0]` <= `sc_head`; `sc[i]` <= `sc[i-1]` for i ≥ 1.
  3. `Test_en`=0 (capture): `sc` <= `func_d`.
- `sc_tail` = `sc[SC_LEN-1]`, taken directly from the flop with no extra logic.
- `func_q` = `sc`.
- Pad direction:
  - `io_oeb[11]` = 0 and `io_oeb[35]` = 0.
  - All other `io_oeb` bits = 1. Direction is constant and not affected by reset or isolation.
- Pad outputs:
  - `io_out[11]` = `sc_tail` & `IO_ISOL_N`.
  - `io_out[35]` = `ccff_tail_i` & `IO_ISOL_N`.
  - All other `io_out` bits = 0.
- `IO_ISOL_N`=0 forces both driven outputs to 0. The scan flops keep operating during isolation.

## Timing
- Reset values: `sc` = 0, `func_q` = 0, `io_out` = 0. `io_oeb` is constant.
- Reset is synchronous: it takes effect only on an `op_clk` edge and has priority over shift and capture, including mid-shift.
- Scan latency: a bit on `sc_head`, sampled at edge k, appears on `sc_tail` after edge k+SC_LEN-1. It is visible when sampled at edge k+SC_LEN.
  - Example, SC_LEN=1024: a pulse sampled at edge 1 is `sc_tail`=1 between edges 1024 and 1025, then 0.
- Capture is single-cycle: `func_d` present at edge k is visible on `func_q` after edge k.
- `Test_en` changing between edges switches the mode for the next edge only; there is no mode-change latency.
- No wrap-around: `sc[SC_LEN-1]` is discarded on each shift.
- `io_out` is combinational from flops and `io_in[1]`; there is no added pad-path register.

## Test plan
- Reset: hold `Reset`=0 for 3 edges with `Test_en`=1 and `sc_head`=1. Required: `sc_tail`=0, `func_q`=0, `io_out`=0, `io_oeb` = all 1 except bits 11 and 35 = 0.
- Single-pulse shift, SC_LEN=1024: `Reset`=1, `Test_en`=1, `IO_ISOL_N`=1, `sc_head`=1 for edge 1 then 0. Required: `io_out[11]`=0 through edge 1023, =1 after edge 1024, =0 after edges 1025 and 1026.
- Capture: `Test_en`=0, `func_d` = alternating 1010…. Required: `func_q` = `func_d` after 1 edge. Then `Test_en`=1 with `sc_head`=0: `sc_tail` reproduces `func_d[SC_LEN-1]`, `[SC_LEN-2]`, … on successive edges.
- Isolation: chain loaded so `sc_tail`=1, `ccff_tail_i`=1, `IO_ISOL_N`=0. Required: `io_out[11]`=`io_out[35]`=0. Raise `IO_ISOL_N`: both become 1 with no clock edge needed.
- Reset mid-shift: after 500 shift edges with a pulse in flight, assert `Reset`=0 for 1 edge. Required: `sc`=0 and no pulse ever reaches `sc_tail`.
